// File: rtl/axis_bram_adapter_v1_0_line_reader_pkg.sv
// Shared state encodings, default geometry and word-select helper for the BRAM line reader.
package axis_bram_adapter_pkg;

  localparam int unsigned DEF_WORDS_PER_LINE = 36;
  localparam int unsigned CNT_W              = $clog2(DEF_WORDS_PER_LINE);

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_WAIT   = 3'd2;
  localparam state_t S_STREAM = 3'd3;
  localparam state_t S_DONE   = 3'd4;

  // Bit offset of word idx inside a packed line of word_w-bit words.
  function automatic int unsigned word_base(input int unsigned idx, input int unsigned word_w);
    return idx * word_w;
  endfunction

endpackage

// File: rtl/axis_bram_adapter_v1_0_line_reader_if.sv
// AXI4-Stream bundle carrying the serialised BRAM words out of the line reader.
interface axis_bram_adapter_v1_0_line_reader_if #(
  parameter int unsigned WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_bram_adapter_v1_0_line_reader_line_buf.sv
// One captured BRAM line with a word-select read port.
module axis_bram_adapter_v1_0_line_buf
  import axis_bram_adapter_pkg::*;
#(
  parameter int unsigned BRAM_WIDTH_IN_WORD = 36,
  parameter int unsigned WORD_WIDTH         = 32,
  parameter int unsigned SEL_W              = 6
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     load,
  input  logic [BRAM_WIDTH_IN_WORD*WORD_WIDTH-1:0] din,
  input  logic [SEL_W-1:0]                         sel,
  output logic [WORD_WIDTH-1:0]                    word
);

  logic [BRAM_WIDTH_IN_WORD*WORD_WIDTH-1:0] q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end
  end

  assign word = q[word_base(32'(sel), WORD_WIDTH) +: WORD_WIDTH];

endmodule

// File: rtl/axis_bram_adapter_v1_0_line_reader.sv
// Reads BRAM lines start..bound (inclusive, wrapping) and serialises them onto an AXI4-Stream master.
// Define AXIS_BRAM_READER_PREFETCH_EN for ping-pong buffering with no bubble between lines.
module axis_bram_adapter_v1_0_line_reader
  import axis_bram_adapter_pkg::*;
#(
  parameter int unsigned BRAM_DEPTH         = 12,
  parameter int unsigned BRAM_WIDTH_IN_WORD = 36,
  parameter int unsigned WORD_WIDTH         = 32,
  parameter int unsigned BRAM_RD_LATENCY    = 2
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     start,
  input  logic [BRAM_DEPTH-1:0]                    bram_start_index,
  input  logic [BRAM_DEPTH-1:0]                    bram_bound_index,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     bram_en,
  output logic [BRAM_DEPTH-1:0]                    bram_index,
  input  logic [BRAM_WIDTH_IN_WORD*WORD_WIDTH-1:0] bram_dout,
  axis_bram_adapter_v1_0_line_reader_if.master     m_axis
);

  localparam int unsigned CW = (BRAM_WIDTH_IN_WORD > 1) ? $clog2(BRAM_WIDTH_IN_WORD) : 1;
  localparam int unsigned L  = BRAM_RD_LATENCY;
  localparam logic [CW-1:0] LAST_WORD = CW'(BRAM_WIDTH_IN_WORD - 1);

  state_t                state;
  logic [BRAM_DEPTH-1:0] cur, bound, cur_next;
  logic [CW-1:0]         cnt;
  logic [L-1:0]          rd_pipe;
  logic                  captured, handshake;

  // rd_pipe tracks each issued read; its MSB marks the cycle bram_dout is valid.
  assign captured  = rd_pipe[L-1];
  assign cur_next  = cur + BRAM_DEPTH'(1);
  assign handshake = m_axis.tvalid & m_axis.tready;

  assign busy          = (state != S_IDLE) && (state != S_DONE);
  assign done          = (state == S_DONE);
  assign m_axis.tvalid = (state == S_STREAM);
  assign m_axis.tlast  = (state == S_STREAM) && (cnt == LAST_WORD) && (cur == bound);

`ifdef AXIS_BRAM_READER_PREFETCH_EN
  logic                  act, pf_full;
  logic [1:0]            load;
  logic [WORD_WIDTH-1:0] word [2];

  // In STREAM the pending read targets the idle buffer; in WAIT it targets the active one.
  assign load = !captured ? 2'b00 : (state == S_STREAM) ? {~act, act} : {act, ~act};

  for (genvar i = 0; i < 2; i++) begin : g_buf
    axis_bram_adapter_v1_0_line_buf #(
      .BRAM_WIDTH_IN_WORD(BRAM_WIDTH_IN_WORD),
      .WORD_WIDTH        (WORD_WIDTH),
      .SEL_W             (CW)
    ) u_buf (
      .clk (clk),
      .rstn(rstn),
      .load(load[i]),
      .din (bram_dout),
      .sel (cnt),
      .word(word[i])
    );
  end

  assign m_axis.tdata = word[act];
`else
  logic [WORD_WIDTH-1:0] word;

  axis_bram_adapter_v1_0_line_buf #(
    .BRAM_WIDTH_IN_WORD(BRAM_WIDTH_IN_WORD),
    .WORD_WIDTH        (WORD_WIDTH),
    .SEL_W             (CW)
  ) u_buf (
    .clk (clk),
    .rstn(rstn),
    .load(captured),
    .din (bram_dout),
    .sel (cnt),
    .word(word)
  );

  assign m_axis.tdata = word;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      cur        <= '0;
      bound      <= '0;
      cnt        <= '0;
      bram_en    <= 1'b0;
      bram_index <= '0;
      rd_pipe    <= '0;
`ifdef AXIS_BRAM_READER_PREFETCH_EN
      act        <= 1'b0;
      pf_full    <= 1'b0;
`endif
    end else begin
      bram_en <= 1'b0;
      rd_pipe <= (rd_pipe << 1) | L'(bram_en);
`ifdef AXIS_BRAM_READER_PREFETCH_EN
      if (captured && state == S_STREAM) pf_full <= 1'b1;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            cur        <= bram_start_index;
            bound      <= bram_bound_index;
            bram_en    <= 1'b1;
            bram_index <= bram_start_index;
            state      <= S_FETCH;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          if (captured) begin
            state <= S_STREAM;
            cnt   <= '0;
`ifdef AXIS_BRAM_READER_PREFETCH_EN
            if (cur != bound) begin
              bram_en    <= 1'b1;
              bram_index <= cur_next;
            end
`endif
          end
        end
        S_STREAM: begin
          if (handshake) begin
            if (cnt != LAST_WORD) begin
              cnt <= cnt + CW'(1);
            end else if (cur == bound) begin
              state <= S_DONE;
            end else begin
              cur <= cur_next;
              cnt <= '0;
`ifdef AXIS_BRAM_READER_PREFETCH_EN
              // Swap now; if the next line has not landed yet, stall in WAIT on the new active buffer.
              act     <= ~act;
              pf_full <= 1'b0;
              if (pf_full || captured) begin
                if (cur_next != bound) begin
                  bram_en    <= 1'b1;
                  bram_index <= cur_next + BRAM_DEPTH'(1);
                end
              end else begin
                state <= S_WAIT;
              end
`else
              bram_en    <= 1'b1;
              bram_index <= cur_next;
              state      <= S_FETCH;
`endif
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
